// File: rtl/quadrature_generator_if.sv
// rtl/quadrature_generator_if.sv - command and status bundle between a stimulus source and quadrature_generator
interface quadrature_generator_if #(
  parameter int MAX_PENDING = 3
);
  localparam int PW = $clog2(MAX_PENDING + 1) + 1;

  logic                 step_up;
  logic                 step_down;
  logic                 press;
  logic                 out_a;
  logic                 out_b;
  logic                 out_switch;
  logic                 busy;
  logic                 step_done;
  logic                 dropped;
  logic signed [PW-1:0] pending;

  modport master (
    output step_up, step_down, press,
    input  out_a, out_b, out_switch, busy, step_done, dropped, pending
  );

  modport slave (
    input  step_up, step_down, press,
    output out_a, out_b, out_switch, busy, step_done, dropped, pending
  );
endinterface

// File: rtl/quadrature_generator.sv
// rtl/quadrature_generator.sv - replays queued step commands as quadrature A/B detents and stretches press commands
// into a fixed-width switch pulse; every output is a register.
module quadrature_generator #(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int PRESS_CYCLES = 6,
  parameter int MAX_PENDING  = 3
) (
  input logic                   clk,
  input logic                   rst,
  quadrature_generator_if.slave bus
);
  localparam int PW = $clog2(MAX_PENDING + 1) + 1;
  localparam int SW = PW + 2;
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int KW = $clog2(PRESS_CYCLES + 1);

  localparam logic [CW-1:0]        PHASE_LOAD = CW'(PHASE_CYCLES - 1);
  localparam logic [GW-1:0]        GAP_LOAD   = GW'(GAP_CYCLES);
  localparam logic [KW-1:0]        PRESS_LOAD = KW'(PRESS_CYCLES);
  localparam logic signed [SW-1:0] MAX_S      = SW'(MAX_PENDING);
  localparam logic signed [SW-1:0] MIN_S      = SW'(-MAX_PENDING);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [CW-1:0]        phase_q, phase_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [KW-1:0]        press_q, press_d;
  logic signed [PW-1:0] pending_q, pending_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;
  logic                 sw_q, sw_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 drop_q, drop_d;

  logic                 start;
  logic                 start_up;
  logic                 start_dn;
  logic                 phase_end;
  logic signed [SW-1:0] sum;

  // The start test looks one cycle ahead of the gap counter so that the back-to-back
  // period is exactly 4*PHASE_CYCLES+GAP_CYCLES.
  assign start     = (state_q == S_IDLE) && (pending_q != '0) && (gap_q <= GW'(1));
  assign start_up  = start && !pending_q[PW-1];
  assign start_dn  = start && pending_q[PW-1];
  assign phase_end = (phase_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      phase_q   <= '0;
      gap_q     <= '0;
      press_q   <= '0;
      pending_q <= '0;
      a_q       <= 1'b1;
      b_q       <= 1'b1;
      sw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      gap_q     <= gap_d;
      press_q   <= press_d;
      pending_q <= pending_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sw_q      <= sw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_P1;
          dir_d   = pending_q[PW-1];
          phase_d = PHASE_LOAD;
        end
      end
      S_P1, S_P2, S_P3: begin
        if (phase_end) begin
          state_d = (state_q == S_P1) ? S_P2 : ((state_q == S_P2) ? S_P3 : S_P4);
          phase_d = PHASE_LOAD;
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end
      S_P4: begin
        if (phase_end) begin
          state_d = S_IDLE;
          gap_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // dir=1 is counter-clockwise: the P1/P3 levels are the mirror of the clockwise ones.
  always_comb begin
    a_d = 1'b1;
    b_d = 1'b1;
    case (state_d)
      S_P1: begin
        a_d = dir_d;
        b_d = !dir_d;
      end
      S_P2: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
      S_P3: begin
        a_d = !dir_d;
        b_d = dir_d;
      end
      default: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE) || (gap_d != '0);
  end

  always_comb begin
    sum = {{2{pending_q[PW-1]}}, pending_q};
    if (bus.step_up) sum = sum + SW'(1);
    if (bus.step_down) sum = sum - SW'(1);
    if (start_up) sum = sum - SW'(1);
    if (start_dn) sum = sum + SW'(1);
    pending_d = sum[PW-1:0];
    drop_d    = 1'b0;
    if (sum > MAX_S) begin
      pending_d = MAX_S[PW-1:0];
      drop_d    = 1'b1;
    end else if (sum < MIN_S) begin
      pending_d = MIN_S[PW-1:0];
      drop_d    = 1'b1;
    end
  end

  always_comb begin
    press_d = press_q;
    if (press_q != '0) begin
      press_d = press_q - KW'(1);
    end else if (bus.press) begin
      press_d = PRESS_LOAD;
    end
    sw_d = (press_d != '0);
  end

  assign bus.out_a      = a_q;
  assign bus.out_b      = b_q;
  assign bus.out_switch = sw_q;
  assign bus.busy       = busy_q;
  assign bus.step_done  = done_q;
  assign bus.dropped    = drop_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_quadrature_generator.sv
// tb/tb_quadrature_generator.sv - bench for quadrature_generator: vector tables, directed sequences
// and random traffic against a timeline model of detents and presses.
module tb_quadrature_generator;
  localparam int PC    = 4;
  localparam int GAP   = 8;
  localparam int PRESS = 6;
  localparam int MAXP  = 3;
  localparam int D     = 4 * PC;
  localparam int GAPE  = (GAP > 0) ? GAP : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  quadrature_generator_if #(.MAX_PENDING(MAXP)) bus ();

  quadrature_generator #(
    .PHASE_CYCLES(PC),
    .GAP_CYCLES  (GAP),
    .PRESS_CYCLES(PRESS),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int up, dn, pr;
    int a, b, sw, busy, done, drop, pend;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;
  int   e = 0;
  int   up_det = 0, dn_det = 0;
  bit   prev_a = 1'b1;

  // Timeline model: a detent is identified by its start edge; everything else follows from arithmetic.
  int m_pend = 0, m_s = -1000, m_next = 0, m_pl = -1000;
  bit m_dir = 1'b0;
  int x_a, x_b, x_sw, x_busy, x_done, x_drop, x_pend;

  function automatic vec_t v(input int n, input int up, input int dn, input int pr, input int a,
                             input int b, input int sw, input int busy, input int done,
                             input int drop, input int pend);
    vec_t r;
    r.n = n; r.up = up; r.dn = dn; r.pr = pr; r.a = a; r.b = b; r.sw = sw;
    r.busy = busy; r.done = done; r.drop = drop; r.pend = pend;
    return r;
  endfunction

  function automatic int ab_of(input bit down, input int ph);
    case (ph)
      0:       return down ? 2 : 1;
      1:       return 0;
      2:       return down ? 1 : 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_step(input int up, input int dn, input int pr, input int r);
    int adj, sum, k, ab;
    e++;
    x_drop = 0;
    if (r != 0) begin
      m_pend = 0; m_s = -1000; m_next = e; m_pl = -1000;
    end else begin
      adj = 0;
      if (!((e - 1 >= m_s) && (e - 1 < m_s + D)) && (e >= m_next) && (m_pend != 0)) begin
        m_s    = e;
        m_dir  = (m_pend < 0);
        m_next = e + D + GAPE;
        adj    = m_dir ? -1 : 1;
      end
      sum = m_pend + ((up != 0) ? 1 : 0) - ((dn != 0) ? 1 : 0) - adj;
      if (sum > MAXP) begin
        sum = MAXP; x_drop = 1;
      end else if (sum < -MAXP) begin
        sum = -MAXP; x_drop = 1;
      end
      m_pend = sum;
      if ((pr != 0) && (e - m_pl > PRESS)) m_pl = e;
    end
    k      = e - m_s;
    x_done = ((r == 0) && (k == D)) ? 1 : 0;
    ab     = ((k >= 0) && (k < D)) ? ab_of(m_dir, k / PC) : 3;
    x_a    = ab / 2;
    x_b    = ab % 2;
    x_busy = (((k >= 0) && (k < D)) || (e < m_next)) ? 1 : 0;
    x_sw   = (e - m_pl < PRESS) ? 1 : 0;
    x_pend = m_pend;
  endtask

  task automatic tick(input int up, input int dn, input int pr, input int r);
    bus.step_up   = (up != 0);
    bus.step_down = (dn != 0);
    bus.press     = (pr != 0);
    rst           = (r != 0);
    model_step(up, dn, pr, r);
    @(posedge clk);
    #1;
    bus.step_up = 1'b0; bus.step_down = 1'b0; bus.press = 1'b0; rst = 1'b0;
    chk("model_a", int'(bus.out_a), x_a);
    chk("model_b", int'(bus.out_b), x_b);
    chk("model_switch", int'(bus.out_switch), x_sw);
    chk("model_busy", int'(bus.busy), x_busy);
    chk("model_done", int'(bus.step_done), x_done);
    chk("model_dropped", int'(bus.dropped), x_drop);
    chk("model_pending", int'($signed(bus.pending)), x_pend);
    if (prev_a && !bus.out_a) begin
      if (bus.out_b) up_det++;
      else dn_det++;
    end
    prev_a = bus.out_a;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vt.size(); i++) begin
      for (int j = 0; j < vt[i].n; j++) begin
        tick((j == 0) ? vt[i].up : 0, (j == 0) ? vt[i].dn : 0, (j == 0) ? vt[i].pr : 0, 0);
        chk({tag, "_a"}, int'(bus.out_a), vt[i].a);
        chk({tag, "_b"}, int'(bus.out_b), vt[i].b);
        chk({tag, "_switch"}, int'(bus.out_switch), vt[i].sw);
        chk({tag, "_busy"}, int'(bus.busy), vt[i].busy);
        chk({tag, "_done"}, int'(bus.step_done), vt[i].done);
        chk({tag, "_dropped"}, int'(bus.dropped), vt[i].drop);
        chk({tag, "_pending"}, int'($signed(bus.pending)), vt[i].pend);
      end
    end
    vt.delete();
  endtask

  initial begin
    int bu, bd, got, nd, pu, pd, pp;
    int dq[$];
    bus.step_up = 1'b0; bus.step_down = 1'b0; bus.press = 1'b0;

    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("reset_a", int'(bus.out_a), 1);
    chk("reset_b", int'(bus.out_b), 1);
    chk("reset_switch", int'(bus.out_switch), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.step_done), 0);
    chk("reset_dropped", int'(bus.dropped), 0);
    chk("reset_pending", int'($signed(bus.pending)), 0);

    // single clockwise detent
    bu = up_det; bd = dn_det;
    vt.push_back(v(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    vt.push_back(v(4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(v(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(4, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
    vt.push_back(v(7, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    vt.push_back(v(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    run_table("up");
    chk("up_detents", up_det - bu, 1);
    chk("up_no_down", dn_det - bd, 0);

    // cancel, single counter-clockwise detent, then a mixed queue during its gap
    tick(0, 0, 0, 1);
    bu = up_det; bd = dn_det;
    tick(1, 1, 0, 0);
    chk("cancel_pending", int'($signed(bus.pending)), 0);
    chk("cancel_dropped", int'(bus.dropped), 0);
    tick(0, 1, 0, 0);
    chk("down_pending", int'($signed(bus.pending)), -1);
    for (int k = 2; k <= 17; k++) begin
      tick(0, 0, 0, 0);
      if (k == 2) chk("down_p1", int'({bus.out_a, bus.out_b}), 2);
      if (k == 6) chk("down_p2", int'({bus.out_a, bus.out_b}), 0);
      if (k == 10) chk("down_p3", int'({bus.out_a, bus.out_b}), 1);
      if (k == 14) chk("down_p4", int'({bus.out_a, bus.out_b}), 3);
    end
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick(0, 0, 0, 0);
      if (bus.step_done) got = 1;
    end
    chk("down_done_seen", got, 1);
    tick(1, 0, 0, 0);
    chk("mix_up", int'($signed(bus.pending)), 1);
    tick(1, 1, 0, 0);
    chk("mix_cancel", int'($signed(bus.pending)), 1);
    tick(0, 1, 0, 0);
    chk("mix_down1", int'($signed(bus.pending)), 0);
    tick(0, 1, 0, 0);
    chk("mix_down2", int'($signed(bus.pending)), -1);
    for (int i = 0; i < 60; i++) tick(0, 0, 0, 0);
    chk("mix_down_detents", dn_det - bd, 2);
    chk("mix_up_detents", up_det - bu, 0);
    chk("mix_pending_end", int'($signed(bus.pending)), 0);

    // saturation
    tick(0, 0, 0, 1);
    bu = up_det;
    vt.push_back(v(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    vt.push_back(v(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    vt.push_back(v(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 2));
    vt.push_back(v(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 3));
    vt.push_back(v(1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 3));
    run_table("sat");
    for (int i = 0; i < 120; i++) begin
      tick(0, 0, 0, 0);
      if (bus.step_done) dq.push_back(e);
    end
    chk("sat_done_count", dq.size(), 4);
    for (int i = 1; i < dq.size(); i++) chk("sat_spacing", dq[i] - dq[i-1], D + GAP);
    chk("sat_up_detents", up_det - bu, 4);

    // press stretching; the second press lands while the switch is held
    tick(0, 0, 0, 1);
    vt.push_back(v(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    vt.push_back(v(3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vt.push_back(v(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    run_table("press");

    // reset during P2 with two detents still queued
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      if (!bus.out_a && !bus.out_b) got = 1;
      else tick(0, 0, 0, 0);
    end
    chk("rst_reached_p2", got, 1);
    chk("rst_pending_before", int'($signed(bus.pending)), 2);
    tick(0, 0, 0, 1);
    chk("rst_a", int'(bus.out_a), 1);
    chk("rst_b", int'(bus.out_b), 1);
    chk("rst_pending", int'($signed(bus.pending)), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.step_done), 0);
    bu = up_det; bd = dn_det; nd = 0;
    for (int i = 0; i < 60; i++) begin
      tick(0, 0, 0, 0);
      if (bus.step_done) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_no_detents", (up_det - bu) + (dn_det - bd), 0);

    // random traffic in windows of differing bias
    tick(0, 0, 0, 1);
    for (int w = 0; w < 20; w++) begin
      case ($urandom_range(0, 2))
        0:       begin pu = 5;  pd = 5;  pp = 4;  end
        1:       begin pu = 40; pd = 5;  pp = 10; end
        default: begin pu = 5;  pd = 40; pp = 10; end
      endcase
      for (int i = 0; i < 200; i++) begin
        tick(($urandom_range(0, 99) < pu) ? 1 : 0, ($urandom_range(0, 99) < pd) ? 1 : 0,
             ($urandom_range(0, 99) < pp) ? 1 : 0, ($urandom_range(0, 599) == 0) ? 1 : 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
